// File: rtl/hbmc_wr_burst_feeder.sv
// Stages FWFT FIFO words into a small prefetch buffer and streams them to the HyperBus PHY, one word per data tick.
// burst_rdy comes one cycle after min(PREFETCH,len) words are staged; the PHY never stalls, so underrun emits masked words.
module hbmc_wr_burst_feeder #(
  parameter int BUF_DEPTH = 4,
  parameter int PREFETCH  = 2,
  parameter int LEN_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 abort,
  output logic                 burst_rdy,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [15:0]          data_dout,
  output logic [1:0]           data_mask,
  output logic                 data_last,
  output logic                 cmd_done,
  output logic                 underrun,
  input  logic [15:0]          fifo_rd_dout,
  input  logic [1:0]           fifo_rd_strb,
  input  logic                 fifo_rd_empty,
  output logic                 fifo_rd_ena
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [PW-1:0]        PTR_ONE = PW'(1);
  localparam logic [LEN_WIDTH-1:0] PF_C    = LEN_WIDTH'(PREFETCH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_BURST} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_WIDTH-1:0] r_words_left;
  logic [LEN_WIDTH-1:0] r_fetch_left;
  logic [CW-1:0]        r_buf_cnt;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [15:0]          r_buf_dat  [BUF_DEPTH];
  logic [1:0]           r_buf_strb [BUF_DEPTH];
  logic                 r_burst_rdy;
  logic                 r_cmd_done;
  logic                 r_underrun;

  logic                 w_accept;
  logic                 w_active;
  logic                 w_buf_empty;
  logic                 w_consume;
  logic                 w_pop;
  logic                 w_skip;
  logic                 w_fetch;
  logic                 w_push;
  logic                 w_last;
  logic                 w_finish;
  logic                 w_flush;
  logic                 w_staged;
  logic                 w_done_nxt;
  logic                 w_brdy_nxt;
  logic [LEN_WIDTH-1:0] w_thresh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = (r_state == S_IDLE) && cmd_valid;
    w_active    = (r_state == S_PRIME) || (r_state == S_BURST);
    w_buf_empty = (r_buf_cnt == '0);
    w_consume   = (r_state == S_BURST) && data_ready && !abort;
    w_pop       = w_consume && !w_buf_empty;
    w_skip      = w_consume && w_buf_empty;
    w_fetch     = w_active && !abort && !fifo_rd_empty && (r_fetch_left != '0) &&
                  ((r_buf_cnt < DEPTH_C) || w_pop);
    // A word fetched while skipping is the very word being skipped: drop it.
    w_push      = w_fetch && !w_skip;
    w_last      = (r_state == S_BURST) && (r_words_left == LEN_ONE);
    w_finish    = w_consume && w_last;
    w_flush     = (w_active && abort) || w_finish;
    w_thresh    = (r_words_left < PF_C) ? r_words_left : PF_C;
    w_staged    = (LEN_WIDTH'(r_buf_cnt) >= w_thresh);
    w_done_nxt  = (w_accept && (cmd_len == '0)) || w_flush;
    w_brdy_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (cmd_len != '0)) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_staged) begin
          w_state_nxt = S_BURST;
          w_brdy_nxt  = 1'b1;
        end
      end
      S_BURST: begin
        if (w_flush) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_words_left <= '0;
      r_fetch_left <= '0;
      r_buf_cnt    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_burst_rdy  <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_burst_rdy <= w_brdy_nxt;
      r_cmd_done  <= w_done_nxt;
      if (w_accept) begin
        r_underrun <= 1'b0;
      end else if (w_skip) begin
        r_underrun <= 1'b1;
      end
      if (w_flush) begin
        r_words_left <= '0;
        r_fetch_left <= '0;
        r_buf_cnt    <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
      end else if (w_accept) begin
        r_words_left <= cmd_len;
        r_fetch_left <= cmd_len;
      end else begin
        if (w_consume)        r_words_left <= r_words_left - LEN_ONE;
        if (w_fetch | w_skip) r_fetch_left <= r_fetch_left - LEN_ONE;
        if (w_push)           r_wr_ptr     <= r_wr_ptr + PTR_ONE;
        if (w_pop)            r_rd_ptr     <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_buf_cnt <= r_buf_cnt + CNT_ONE;
          2'b01:   r_buf_cnt <= r_buf_cnt - CNT_ONE;
          default: r_buf_cnt <= r_buf_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_dat[r_wr_ptr]  <= fifo_rd_dout;
      r_buf_strb[r_wr_ptr] <= fifo_rd_strb;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign burst_rdy   = r_burst_rdy;
  assign data_valid  = (r_state == S_BURST);
  assign data_dout   = (data_valid && !w_buf_empty) ? r_buf_dat[r_rd_ptr] : 16'h0000;
  assign data_mask   = (data_valid && !w_buf_empty) ? ~r_buf_strb[r_rd_ptr] : 2'b11;
  assign data_last   = w_last;
  assign cmd_done    = r_cmd_done;
  assign underrun    = r_underrun;
  assign fifo_rd_ena = w_fetch;

endmodule

// File: tb/tb_hbmc_wr_burst_feeder.sv
// Directed bench for hbmc_wr_burst_feeder with an FWFT FIFO model; inputs change and outputs are sampled on the falling edge.
module tb_hbmc_wr_burst_feeder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_len;
  logic        abort;
  logic        burst_rdy;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] data_dout;
  logic [1:0]  data_mask;
  logic        data_last;
  logic        cmd_done;
  logic        underrun;
  logic [15:0] fifo_rd_dout;
  logic [1:0]  fifo_rd_strb;
  logic        fifo_rd_empty;
  logic        fifo_rd_ena;

  int checks = 0;
  int errors = 0;

  hbmc_wr_burst_feeder #(.BUF_DEPTH(4), .PREFETCH(2), .LEN_WIDTH(9)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .abort(abort),
    .burst_rdy(burst_rdy), .data_valid(data_valid), .data_ready(data_ready),
    .data_dout(data_dout), .data_mask(data_mask), .data_last(data_last),
    .cmd_done(cmd_done), .underrun(underrun),
    .fifo_rd_dout(fifo_rd_dout), .fifo_rd_strb(fifo_rd_strb),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_ena(fifo_rd_ena)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model: head visible combinationally, popped on the rising edge
  logic [17:0] fmem [64];
  int   wr_idx = 0;
  int   rd_idx = 0;
  int   ena_cnt = 0;
  int   bad_ena = 0;
  logic fifo_flush = 1'b0;

  assign fifo_rd_empty = (rd_idx == wr_idx);
  assign fifo_rd_dout  = fmem[rd_idx][15:0];
  assign fifo_rd_strb  = fmem[rd_idx][17:16];

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_idx <= wr_idx;
    end else if (fifo_rd_ena) begin
      ena_cnt <= ena_cnt + 1;
      if (fifo_rd_empty) bad_ena <= bad_ena + 1;
      else               rd_idx  <= rd_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] s);
    fmem[wr_idx] = {s, d};
    wr_idx++;
  endtask

  task automatic flush_fifo();
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_burst_rdy"}, burst_rdy, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_data_dout"}, data_dout, 0);
    chk({tag, "_data_mask"}, data_mask, 2'b11);
    chk({tag, "_data_last"}, data_last, 0);
    chk({tag, "_cmd_done"}, cmd_done, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_fifo_rd_ena"}, fifo_rd_ena, 0);
  endtask

  // Issue at a falling edge; returns at the falling edge of the first cycle after accept.
  task automatic send_cmd(input logic [8:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits for burst_rdy; returns at the falling edge where it is seen, reporting cycles since accept.
  task automatic wait_brdy(input string tag, input int exp_cycles);
    int n = 1;
    while (!burst_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_brdy_seen"}, burst_rdy, 1);
    chk({tag, "_brdy_cycle"}, n, exp_cycles);
  endtask

  task automatic exp_word(input string tag, input logic [15:0] d, input logic [1:0] m, input logic l);
    chk({tag, "_vld"}, data_valid, 1);
    chk({tag, "_dat"}, data_dout, d);
    chk({tag, "_mask"}, data_mask, m);
    chk({tag, "_last"}, data_last, l);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_len = '0; abort = 1'b0; data_ready = 1'b0;
    #1;
    chk_idle("rst_async");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("rst_rel");

    // Basic 4-word burst: 1 accept edge + 3 PRIME cycles before burst_rdy
    push(16'h1111, 2'b11); push(16'h2222, 2'b11); push(16'h3333, 2'b11); push(16'h4444, 2'b11);
    data_ready = 1'b1;
    e0 = ena_cnt;
    send_cmd(9'd4);
    wait_brdy("t1", 4);
    exp_word("t1_w1", 16'h1111, 2'b00, 0);
    exp_word("t1_w2", 16'h2222, 2'b00, 0);
    exp_word("t1_w3", 16'h3333, 2'b00, 0);
    exp_word("t1_w4", 16'h4444, 2'b00, 1);
    chk("t1_done", cmd_done, 1);
    chk("t1_idle", cmd_ready, 1);
    chk("t1_vld_off", data_valid, 0);
    chk("t1_underrun", underrun, 0);
    chk("t1_pops", ena_cnt - e0, 4);
    @(negedge clk);
    chk("t1_done_pulse", cmd_done, 0);

    // Strobe to RWDS mask inversion
    push(16'hA5A5, 2'b01); push(16'h5A5A, 2'b10);
    send_cmd(9'd2);
    wait_brdy("t2", 4);
    exp_word("t2_w1", 16'hA5A5, 2'b10, 0);
    exp_word("t2_w2", 16'h5A5A, 2'b01, 1);
    chk("t2_done", cmd_done, 1);

    // Never fetches past cmd_len; the next burst picks up the remainder in order
    for (int i = 1; i <= 8; i++) push(16'h3000 + 16'(i), 2'b11);
    e0 = ena_cnt;
    send_cmd(9'd3);
    wait_brdy("t3a", 4);
    exp_word("t3a_w1", 16'h3001, 2'b00, 0);
    exp_word("t3a_w2", 16'h3002, 2'b00, 0);
    exp_word("t3a_w3", 16'h3003, 2'b00, 1);
    chk("t3a_done", cmd_done, 1);
    chk("t3a_pops", ena_cnt - e0, 3);
    @(negedge clk);
    chk("t3a_pops_hold", ena_cnt - e0, 3);
    send_cmd(9'd5);
    wait_brdy("t3b", 4);
    exp_word("t3b_w4", 16'h3004, 2'b00, 0);
    exp_word("t3b_w5", 16'h3005, 2'b00, 0);
    exp_word("t3b_w6", 16'h3006, 2'b00, 0);
    exp_word("t3b_w7", 16'h3007, 2'b00, 0);
    exp_word("t3b_w8", 16'h3008, 2'b00, 1);
    chk("t3b_done", cmd_done, 1);
    chk("t3b_pops", ena_cnt - e0, 8);

    // Underrun: 2 words available for a 4-word burst
    push(16'h4401, 2'b11); push(16'h4402, 2'b11);
    e0 = ena_cnt;
    send_cmd(9'd4);
    wait_brdy("t4", 4);
    exp_word("t4_w1", 16'h4401, 2'b00, 0);
    exp_word("t4_w2", 16'h4402, 2'b00, 0);
    chk("t4_ur_before", underrun, 0);
    exp_word("t4_w3", 16'h0000, 2'b11, 0);
    chk("t4_ur_set", underrun, 1);
    exp_word("t4_w4", 16'h0000, 2'b11, 1);
    chk("t4_done", cmd_done, 1);
    chk("t4_pops", ena_cnt - e0, 2);
    repeat (3) @(negedge clk);
    chk("t4_ur_sticky", underrun, 1);

    // Abort after 2 of 6 words; the accept also clears the sticky underrun
    for (int i = 1; i <= 6; i++) push(16'h5000 + 16'(i), 2'b11);
    send_cmd(9'd6);
    chk("t5_ur_clear", underrun, 0);
    wait_brdy("t5", 4);
    exp_word("t5_w1", 16'h5001, 2'b00, 0);
    exp_word("t5_w2", 16'h5002, 2'b00, 0);
    abort = 1'b1;
    #1;
    chk("t5_no_ena_abort", fifo_rd_ena, 0);
    e0 = ena_cnt;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_done", cmd_done, 1);
    chk("t5_idle", cmd_ready, 1);
    chk("t5_vld_off", data_valid, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_more_pops", ena_cnt - e0, 0);
    chk("t5_done_pulse", cmd_done, 0);
    flush_fifo();

    // Empty burst
    e0 = ena_cnt;
    cmd_valid = 1'b1;
    cmd_len   = 9'd0;
    chk("t6_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_done", cmd_done, 1);
    chk("t6_no_brdy", burst_rdy, 0);
    chk("t6_stay_idle", cmd_ready, 1);
    @(negedge clk);
    chk("t6_done_pulse", cmd_done, 0);
    chk("t6_no_pops", ena_cnt - e0, 0);

    // Reset asserted mid-burst, away from any clock edge
    push(16'h7001, 2'b11); push(16'h7002, 2'b11); push(16'h7003, 2'b11); push(16'h7004, 2'b11);
    send_cmd(9'd4);
    wait_brdy("t7", 4);
    exp_word("t7_w1", 16'h7001, 2'b00, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle("t7_rst");
    @(negedge clk);
    rstn = 1'b1;
    flush_fifo();
    chk("t7_no_done", cmd_done, 0);
    chk("t7_ready", cmd_ready, 1);

    chk("no_ena_while_empty", bad_ena, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbmc_wr_burst_feeder.md
Name: hbmc_wr_burst_feeder

Overview:
Read-side consumer of the downstream data FIFO, in the memory-clock domain. Pops 16-bit words plus byte strobes from the FWFT FIFO into a small local prefetch buffer. Once enough data is staged it signals the HyperBus write sequencer, then presents one word per PHY data tick with RWDS mask bits. The PHY cannot stall, so FIFO underrun is absorbed by emitting fully-masked words and raising a sticky error.

Parameters:
BUF_DEPTH, 4, local prefetch buffer entries; power of two, >= 2
PREFETCH, 2, words staged before burst_rdy asserts; 1..BUF_DEPTH
LEN_WIDTH, 9, width of burst length in 16-bit words

Ports:
clk  in  1  memory-domain clock (FIFO read clock)
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  burst request from write sequencer
cmd_ready  out  1  high in IDLE only
cmd_len  in  LEN_WIDTH  burst length in words; 0 = empty burst
abort  in  1  sequencer terminates current burst
burst_rdy  out  1  staging complete, sequencer may start the data phase
data_valid  out  1  high throughout BURST
data_ready  in  1  PHY consumes one word this cycle
data_dout  out  16  word to transmit
data_mask  out  2  RWDS mask, = ~strb; 2'b11 = both bytes masked
data_last  out  1  current word is the final word of the burst
cmd_done  out  1  one-cycle pulse when burst completes or aborts
underrun  out  1  sticky; set on consume-while-empty, cleared by next cmd accept
fifo_rd_dout  in  16  FWFT FIFO head data
fifo_rd_strb  in  2  FWFT FIFO head strobes
fifo_rd_empty  in  1  FIFO empty
fifo_rd_ena  out  1  pop FIFO head

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, buffer empty, counters 0. Outputs: cmd_ready=1, burst_rdy=0, data_valid=0, data_dout=0, data_mask=2'b11, data_last=0, cmd_done=0, underrun=0, fifo_rd_ena=0.
- Counters: words_left (words still to emit) and fetch_left (words still to pull from the FIFO), both LEN_WIDTH. buf_cnt ranges 0..BUF_DEPTH.
- IDLE: cmd_ready=1.
  - On cmd_valid: load words_left=fetch_left=cmd_len and clear underrun.
  - If cmd_len==0: pulse cmd_done next cycle, stay IDLE.
  - Otherwise go to PRIME.
- Fetch (PRIME and BURST): fifo_rd_ena = ~fifo_rd_empty & (fetch_left!=0) & (buf_cnt<BUF_DEPTH | pop_this_cycle).
  - fifo_rd_ena is never asserted while fifo_rd_empty=1.
  - The word is captured into the buffer on the same edge as the pop; fetch_left decrements.
  - Never fetches past cmd_len, so the next burst's words stay in the FIFO.
- PRIME: when buf_cnt >= min(PREFETCH, words_left), go to BURST. burst_rdy is registered and high for the first BURST cycle.
- BURST: data_valid=1.
  - data_dout/data_mask come from the buffer head when buf_cnt>0. Otherwise 16'h0000 / 2'b11.
  - data_last = (words_left==1).
  - On data_ready with buf_cnt>0: pop the head, decrement words_left.
  - On data_ready with buf_cnt==0: emit the masked zero word, decrement words_left, set underrun, decrement fetch_left. The missing FIFO word is treated as skipped, keeping alignment.
  - On data_ready & data_last: go to IDLE and pulse cmd_done.
- Simultaneous fetch and pop: buf_cnt unchanged; both pointers advance.
- Buffer pointers wrap modulo BUF_DEPTH.
- abort (PRIME or BURST, highest priority):
  - Next cycle: IDLE, buffer flushed, counters 0, cmd_done pulse.
  - No fifo_rd_ena in the abort cycle.
  - Unfetched words remain in the FIFO; the owner flushes via FIFO reset.
- abort in IDLE is ignored.
- cmd_valid is ignored outside IDLE.
- Reset mid-burst returns to the reset state immediately. No cmd_done is generated.

Test Plan:
- FIFO preloaded with 4 words 0x1111..0x4444, strb 2'b11; cmd_len=4, data_ready held 1 -> burst_rdy after 2 words staged; data_dout 0x1111,0x2222,0x3333,0x4444 on consecutive cycles; data_mask 2'b00; data_last on 0x4444; cmd_done next cycle; underrun=0.
- Strobe pattern 2'b01,2'b10 on 2 words -> data_mask 2'b10 then 2'b01.
- FIFO holds 8 words, cmd_len=3 -> exactly 3 fifo_rd_ena pulses; second cmd_len=5 emits words 4..8 in order.
- cmd_len=4, only 2 words available, data_ready=1 -> words 1,2 then 16'h0000 mask 2'b11 twice; underrun=1 until next cmd accept.
- abort asserted after 2 of 6 words consumed -> cmd_done pulse, cmd_ready=1 next cycle, no further fifo_rd_ena.
- cmd_len=0 -> no burst_rdy, no fifo_rd_ena, cmd_done one cycle after accept; rstn pulse mid-burst -> all outputs at reset values asynchronously.
